// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WORD_W = DATA_W - 2;
  localparam int unsigned ID_W   = 1;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Per-access context held from grant until the response retires.
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            we;
    logic            in_range;
  } xfer_t;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick; ptr=0 favours port 0 on a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // After a grant the other port is favoured next time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance && (|gnt)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU data port (0) and a loader (1).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  state_e            state;
  xfer_t             xfer;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        arb_gnt;
  logic              idle;
  logic              sel;
  logic              sel_we;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;
  logic [DATA_W-1:0] cap_data;
  logic              to_p0;

  assign idle = (state == ST_IDLE);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({m1_req, m0_req}),
    .advance (idle),
    .gnt     (arb_gnt)
  );

  // Grants are only offered from IDLE and are visible in the same cycle.
  assign m0_gnt = idle & arb_gnt[0];
  assign m1_gnt = idle & arb_gnt[1];

  assign sel          = arb_gnt[1];
  assign sel_we       = sel ? m1_we    : m0_we;
  assign sel_addr     = sel ? m1_addr  : m0_addr;
  assign sel_wdata    = sel ? m1_wdata : m0_wdata;
  assign sel_in_range = sel_addr[DATA_W-1:2] < WORD_W'(DEPTH);

  // Writes and out-of-range accesses always report zero data.
  assign cap_data = (xfer.we || !xfer.in_range) ? '0 : mem_rd;
  assign to_p0    = (xfer.id == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      xfer      <= '0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|arb_gnt) begin
            xfer.id       <= ID_W'(sel);
            xfer.we       <= sel_we;
            xfer.in_range <= sel_in_range;
            cnt           <= CNT_W'(WAIT_STATES);
            mem_addr      <= sel_addr & ~DATA_W'(3);
            mem_wd        <= sel_wdata;
            mem_we        <= (WAIT_STATES == 0) && sel_we && sel_in_range;
            state         <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt != '0) begin
            cnt    <= cnt - CNT_W'(1);
            // Strobe lands in the cycle where the counter reaches zero.
            mem_we <= (cnt == CNT_W'(1)) && xfer.we && xfer.in_range;
          end else begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
            m0_rvalid <= to_p0;
            m0_rdata  <= to_p0 ? cap_data : '0;
            m0_err    <= to_p0 && !xfer.in_range;
            m1_rvalid <= !to_p0;
            m1_rdata  <= to_p0 ? '0 : cap_data;
            m1_err    <= !to_p0 && !xfer.in_range;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          m0_rvalid <= 1'b0;
          m0_rdata  <= '0;
          m0_err    <= 1'b0;
          m1_rvalid <= 1'b0;
          m1_rdata  <= '0;
          m1_err    <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: two arbiter instances (1 and 3 wait states), each with a small memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Instance A: WAIT_STATES=1
  logic        a_reset;
  logic        a_m0_req, a_m0_we, a_m0_gnt, a_m0_rvalid, a_m0_err;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m0_rdata;
  logic        a_m1_req, a_m1_we, a_m1_gnt, a_m1_rvalid, a_m1_err;
  logic [31:0] a_m1_addr, a_m1_wdata, a_m1_rdata;
  logic        a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wd, a_mem_rd;
  logic [31:0] mem_a [0:63];
  int          a_we_cnt = 0;

  // Instance B: WAIT_STATES=3
  logic        b_reset;
  logic        b_m0_req, b_m0_we, b_m0_gnt, b_m0_rvalid, b_m0_err;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata;
  logic        b_m1_req, b_m1_we, b_m1_gnt, b_m1_rvalid, b_m1_err;
  logic [31:0] b_m1_addr, b_m1_wdata, b_m1_rdata;
  logic        b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wd, b_mem_rd;
  logic [31:0] mem_b [0:63];
  int          b_we_cnt = 0;

  dmem_arbiter #(.DEPTH(64), .WAIT_STATES(1)) u_a (
    .clk(clk), .reset(a_reset),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata), .m0_err(a_m0_err),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata), .m1_err(a_m1_err),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wd(a_mem_wd), .mem_rd(a_mem_rd)
  );

  dmem_arbiter #(.DEPTH(64), .WAIT_STATES(3)) u_b (
    .clk(clk), .reset(b_reset),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wd(b_mem_wd), .mem_rd(b_mem_rd)
  );

  // Memory models: combinational read, write on the rising edge.
  assign a_mem_rd = (a_mem_addr[31:2] < 30'd64) ? mem_a[a_mem_addr[7:2]] : 32'h0;
  assign b_mem_rd = (b_mem_addr[31:2] < 30'd64) ? mem_b[b_mem_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (a_mem_we) begin
      a_we_cnt <= a_we_cnt + 1;
      if (a_mem_addr[31:2] < 30'd64) mem_a[a_mem_addr[7:2]] <= a_mem_wd;
    end
    if (b_mem_we) begin
      b_we_cnt <= b_we_cnt + 1;
      if (b_mem_addr[31:2] < 30'd64) mem_b[b_mem_addr[7:2]] <= b_mem_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_a_sig();
    logic [31:0] s = 32'h0;
    for (int i = 0; i < 64; i++) s = {s[30:0], s[31]} ^ mem_a[i] ^ 32'(i);
    return s;
  endfunction

  int          gseq [0:7];
  int          ng;
  int          nrv;
  int          we_before;
  logic [31:0] sig_before;
  int          exp_order [0:3];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[3] = 32'hDEADBEEF;
    a_reset = 1'b1; b_reset = 1'b1;
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0;
    a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
    step(); step();

    // Reset state
    check("rst_a_mem_we", 32'(a_mem_we), 32'h0);
    check("rst_a_mem_addr", a_mem_addr, 32'h0);
    check("rst_a_m0_rvalid", 32'(a_m0_rvalid), 32'h0);
    check("rst_a_m1_rdata", a_m1_rdata, 32'h0);
    check("rst_b_mem_wd", b_mem_wd, 32'h0);
    a_reset = 1'b0;
    step(); #1;
    check("idle_a_gnt", 32'({a_m1_gnt, a_m0_gnt}), 32'h0);
    check("idle_a_mem_addr", a_mem_addr, 32'h0);

    // m0 read of word 3
    step();
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h0C; #1;
    check("t1_m0_gnt", 32'(a_m0_gnt), 32'h1);
    check("t1_m1_gnt", 32'(a_m1_gnt), 32'h0);
    step(); a_m0_req = 0; a_m0_addr = 0; #1;
    check("t1_acc1_we", 32'(a_mem_we), 32'h0);
    check("t1_acc1_addr", a_mem_addr, 32'h0C);
    step();
    check("t1_acc2_we", 32'(a_mem_we), 32'h0);
    step();
    check("t1_rvalid", 32'(a_m0_rvalid), 32'h1);
    check("t1_rdata", a_m0_rdata, 32'hDEADBEEF);
    check("t1_err", 32'(a_m0_err), 32'h0);
    check("t1_m1_rvalid", 32'(a_m1_rvalid), 32'h0);
    check("t1_m1_rdata", a_m1_rdata, 32'h0);
    step();
    check("t1_rvalid_drop", 32'(a_m0_rvalid), 32'h0);
    check("t1_rdata_drop", a_m0_rdata, 32'h0);

    // m1 write, then m0 reads it back
    a_m1_req = 1; a_m1_we = 1; a_m1_addr = 32'h10; a_m1_wdata = 32'h12345678; #1;
    check("t2_m1_gnt", 32'(a_m1_gnt), 32'h1);
    check("t2_m0_gnt", 32'(a_m0_gnt), 32'h0);
    step(); a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0; #1;
    check("t2_acc1_we", 32'(a_mem_we), 32'h0);
    step();
    check("t2_strobe_we", 32'(a_mem_we), 32'h1);
    check("t2_strobe_addr", a_mem_addr, 32'h10);
    check("t2_strobe_wd", a_mem_wd, 32'h12345678);
    step();
    check("t2_we_off", 32'(a_mem_we), 32'h0);
    check("t2_m1_rvalid", 32'(a_m1_rvalid), 32'h1);
    check("t2_m1_err", 32'(a_m1_err), 32'h0);
    check("t2_m0_rvalid", 32'(a_m0_rvalid), 32'h0);
    check("t2_mem_word4", mem_a[4], 32'h12345678);
    step();
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h10; #1;
    check("t2_rb_gnt", 32'(a_m0_gnt), 32'h1);
    step(); a_m0_req = 0; a_m0_addr = 0;
    step(); step();
    check("t2_rb_rvalid", 32'(a_m0_rvalid), 32'h1);
    check("t2_rb_rdata", a_m0_rdata, 32'h12345678);
    step();

    // Out-of-range write
    sig_before = mem_a_sig();
    we_before  = a_we_cnt;
    a_m0_req = 1; a_m0_we = 1; a_m0_addr = 32'h100; a_m0_wdata = 32'hFFFFFFFF; #1;
    check("t4_gnt", 32'(a_m0_gnt), 32'h1);
    step(); a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0;
    step(); step();
    check("t4_rvalid", 32'(a_m0_rvalid), 32'h1);
    check("t4_err", 32'(a_m0_err), 32'h1);
    check("t4_rdata", a_m0_rdata, 32'h0);
    step();
    check("t4_no_strobe", 32'(a_we_cnt - we_before), 32'h0);
    check("t4_mem_unchanged", mem_a_sig(), sig_before);
    check("t4_err_drop", 32'(a_m0_err), 32'h0);

    // Misaligned read of word 3
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h0F; #1;
    check("t6_gnt", 32'(a_m0_gnt), 32'h1);
    step(); a_m0_req = 0; a_m0_addr = 0; #1;
    check("t6_mem_addr", a_mem_addr, 32'h0C);
    step(); step();
    check("t6_rdata", a_m0_rdata, 32'hDEADBEEF);
    check("t6_err", 32'(a_m0_err), 32'h0);
    step();

    // Fairness from reset with both ports requesting continuously
    a_reset = 1'b1; #1;
    check("t3_rst_mem_addr", a_mem_addr, 32'h0);
    step(); a_reset = 1'b0;
    mem_a[1] = 32'h11111111;
    mem_a[2] = 32'h22222222;
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h04;
    a_m1_req = 1; a_m1_we = 0; a_m1_addr = 32'h08;
    ng = 0; nrv = 0;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (a_m0_gnt && ng < 8) begin gseq[ng] = 0; ng++; end
      if (a_m1_gnt && ng < 8) begin gseq[ng] = 1; ng++; end
      if (a_m0_rvalid) begin
        nrv++;
        check("t3_m0_rdata", a_m0_rdata, 32'h11111111);
        check("t3_m0_excl", 32'(a_m1_rvalid), 32'h0);
      end
      if (a_m1_rvalid) begin
        nrv++;
        check("t3_m1_rdata", a_m1_rdata, 32'h22222222);
        check("t3_m1_excl", 32'(a_m0_rvalid), 32'h0);
      end
      step();
    end
    a_m0_req = 0; a_m1_req = 0;
    check("t3_gnt_count", 32'(ng), 32'd4);
    check("t3_rvalid_count", 32'(nrv), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_order%0d", k), (k < ng) ? 32'(gseq[k]) : 32'hFFFFFFFF, 32'(exp_order[k]));
    end

    // Reset mid-access with 3 wait states drops the write
    b_reset = 1'b0;
    step();
    b_m1_req = 1; b_m1_we = 1; b_m1_addr = 32'h20; b_m1_wdata = 32'hCAFEF00D; #1;
    check("t5_gnt", 32'(b_m1_gnt), 32'h1);
    step(); b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
    step(); #1;
    check("t5_pre_addr", b_mem_addr, 32'h20);
    b_reset = 1'b1; #1;
    check("t5_rst_addr", b_mem_addr, 32'h0);
    check("t5_rst_wd", b_mem_wd, 32'h0);
    check("t5_rst_we", 32'(b_mem_we), 32'h0);
    step(); step();
    b_reset = 1'b0;
    nrv = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (b_m0_rvalid || b_m1_rvalid) nrv++;
      step();
    end
    check("t5_no_rvalid", 32'(nrv), 32'h0);
    check("t5_no_strobe", 32'(b_we_cnt), 32'h0);
    check("t5_mem_word8", mem_b[8], 32'h0);
    b_m0_req = 1; b_m0_addr = 32'h0;
    b_m1_req = 1; b_m1_addr = 32'h4; #1;
    check("t5_next_gnt0", 32'(b_m0_gnt), 32'h1);
    check("t5_next_gnt1", 32'(b_m1_gnt), 32'h0);
    step(); b_m0_req = 0; b_m1_req = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
